// File: rtl/serial_add_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_seq_pkg
// Description : Shared definitions for the nibble-serial adder/subtractor.
//               Holds the nibble width constant and the controller state
//               encoding used by serial_add_seq.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_add_seq_pkg;

    // Width of one adder slice; operands are processed this many bits a cycle.
    localparam int NIB = 4;

    // Controller states, explicit 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage : serial_add_seq_pkg
`default_nettype wire

// File: rtl/serial_add_seq_rca4.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_seq_rca4
// Description : 4-bit ripple-carry adder built from full-adder cells.
// Ports       : x, y  - 4-bit addends
//               cin   - carry in
//               s     - 4-bit sum
//               co    - carry out of bit 3
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_seq_rca4
    import serial_add_seq_pkg::*;
(
    input  logic [NIB-1:0] x,
    input  logic [NIB-1:0] y,
    input  logic           cin,
    output logic [NIB-1:0] s,
    output logic           co
);

    logic [NIB:0] w_c;

    assign w_c[0] = cin;

    generate
        for (genvar i = 0; i < NIB; i++) begin : g_bit
            assign s[i]     = x[i] ^ y[i] ^ w_c[i];
            assign w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
        end
    endgenerate

    assign co = w_c[NIB];

endmodule : serial_add_seq_rca4
`default_nettype wire

// File: rtl/serial_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_seq
// Description : Nibble-serial adder/subtractor. One shared 4-bit ripple adder
//               processes the operands LSB nibble first, one nibble per
//               clock. Subtraction is a + ~b + 1.
// Ports       : clk, rst             - clock, synchronous active-high reset
//               in_valid / in_ready  - request handshake (a, b, sub)
//               out_valid / out_ready- result handshake (sum, cout, ovf)
//               cout                 - carry out of MSB nibble (sub: 1 = no borrow)
//               ovf                  - two's-complement signed overflow
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_seq
    import serial_add_seq_pkg::*;
#(
    parameter int N_NIB = 4,
    parameter int W     = NIB * N_NIB
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int                 c_IDX_W    = $clog2(N_NIB);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(N_NIB - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_sum;
    logic               r_carry;
    logic               r_op;
    logic [c_IDX_W-1:0] r_idx;

    logic [NIB-1:0]     w_x;
    logic [NIB-1:0]     w_y;
    logic [NIB-1:0]     w_s;
    logic               w_cin;
    logic               w_co;
    logic               w_last;

    assign w_last = (r_idx == c_IDX_LAST);

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                // Returning to IDLE (not straight to RUN) is what keeps a
                // request from being accepted on the same edge a result leaves.
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    assign w_x = r_a[r_idx*NIB +: NIB];
    assign w_y = r_b[r_idx*NIB +: NIB];

    // On the first nibble the carry-in is the operation bit (the +1 of the
    // two's-complement negate); r_carry holds the same value there, later
    // nibbles chain through r_carry.
    assign w_cin = (r_idx == '0) ? r_op : r_carry;

    serial_add_seq_rca4 u_rca4 (
        .x   (w_x),
        .y   (w_y),
        .cin (w_cin),
        .s   (w_s),
        .co  (w_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_op    <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b ^ {W{sub}};
                        r_carry <= sub;
                        r_op    <= sub;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    r_sum[r_idx*NIB +: NIB] <= w_s;
                    r_carry                 <= w_co;
                    // Index parks on the last nibble rather than wrapping.
                    if (!w_last) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_carry;
    // Overflow uses the stored (already inverted for sub) B operand.
    assign ovf  = (r_a[W-1] == r_b[W-1]) && (r_sum[W-1] != r_a[W-1]);

endmodule : serial_add_seq
`default_nettype wire

// File: tb/tb_serial_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_add_seq
// Description : Directed self-checking bench for serial_add_seq (N_NIB = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_seq;

    localparam int N_NIB = 4;
    localparam int W     = 4 * N_NIB;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    serial_add_seq #(.N_NIB(N_NIB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full operation from IDLE: accept, latency, result, handshake.
    task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tsub,
                      input logic [W-1:0] es, input logic ec, input logic eo, input string tag);
        a = ta; b = tb_v; sub = tsub; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = ~ta; b = 16'hA5A5; sub = ~tsub;   // must not disturb the running op
        chk({tag, "_in_ready_run"}, in_ready, 1'b0);
        repeat (N_NIB - 1) tick();
        chk({tag, "_not_early"}, out_valid, 1'b0);
        tick();
        chk({tag, "_out_valid"}, out_valid, 1'b1);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, cout, ec);
        chk({tag, "_ovf"}, ovf, eo);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_back_idle"}, {in_ready, out_valid}, 2'b10);
    endtask

    initial begin
        logic [W-1:0] ra, rb, bb;
        logic         rs;
        logic [W:0]   full;
        logic         eovf;
        int           last_cyc;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0;
        repeat (2) tick();
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_sum", sum, 16'h0000);
        chk("rst_cout", cout, 1'b0);
        chk("rst_ovf", ovf, 1'b0);

        // out_ready outside DONE does nothing
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("oready_idle", {in_ready, out_valid}, 2'b10);

        // Directed arithmetic
        op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, "add_basic");
        op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "add_carry");
        op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
        op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
        op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
        op(16'h0003, 16'h0003, 1'b1, 16'h0000, 1'b1, 1'b0, "sub_zero");

        // Stall in DONE with a new request pending
        a = 16'h00FF; b = 16'h0F01; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (N_NIB) tick();
        chk("stall_entry_valid", out_valid, 1'b1);
        in_valid = 1'b1; a = 16'h1111; b = 16'h2222; sub = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_hold", {in_ready, out_valid, cout, sum}, {1'b0, 1'b1, 1'b0, 16'h1000});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("stall_release_idle", {in_ready, out_valid}, 2'b10);
        tick();
        in_valid = 1'b0;
        chk("stall_next_accept", in_ready, 1'b0);
        repeat (N_NIB) tick();
        chk("stall_next_result", {out_valid, cout, ovf, sum}, {1'b1, 1'b0, 1'b0, 16'h3333});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset mid-RUN discards the partial result
        a = 16'h1234; b = 16'h1111; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_state", {in_ready, out_valid}, 2'b10);
        chk("midrst_sum", sum, 16'h0000);
        chk("midrst_cout_ovf", {cout, ovf}, 2'b00);
        op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, "after_rst");

        // Reset in DONE with out_ready=1
        a = 16'h0F0F; b = 16'h0101; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (N_NIB) tick();
        rst = 1'b1; out_ready = 1'b1;
        tick();
        rst = 1'b0; out_ready = 1'b0;
        chk("donerst", {in_ready, out_valid, cout, ovf, sum}, {4'b1000, 16'h0000});

        // Back-to-back random operations, out_ready tied high
        out_ready = 1'b1;
        last_cyc  = 0;
        for (int k = 0; k < 1000; k++) begin
            ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
            bb   = rs ? ~rb : rb;
            full = {1'b0, ra} + {1'b0, bb} + {{W{1'b0}}, rs};
            eovf = (ra[W-1] == bb[W-1]) && (full[W-1] != ra[W-1]);
            a = ra; b = rb; sub = rs; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
            repeat (N_NIB - 1) tick();
            if (out_valid !== 1'b0) chk("rnd_not_early", out_valid, 1'b0);
            tick();
            chk("rnd_result", {out_valid, cout, eovf ^ ovf ^ eovf, sum},
                {1'b1, full[W], eovf, full[W-1:0]});
            if (k > 0) chk("rnd_period", cyc - last_cyc, N_NIB + 2);
            last_cyc = cyc;
            tick();
        end
        out_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_serial_add_seq
`default_nettype wire

// File: doc/serial_add_seq.md
SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

Interface
REQ-001 SHALL have parameter N_NIB, default 4: number of 4-bit nibbles per operand, legal range 2..8.
REQ-002 SHALL have parameter W, default 4*N_NIB: operand width, derived and not overridden.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: an operation request is present.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a request this cycle.
REQ-007 SHALL have port a, input, W bits: first operand.
REQ-008 SHALL have port b, input, W bits: second operand.
REQ-009 SHALL have port sub, input, 1 bit: 0 selects a+b; 1 selects a-b.
REQ-010 SHALL have port out_valid, output, 1 bit: result is present.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-012 SHALL have port sum, output, W bits: result.
REQ-013 SHALL have port cout, output, 1 bit: carry out of the MSB nibble (for sub: 1 means no borrow).
REQ-014 SHALL have port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-015 SHALL sequence one shared 4-bit ripple adder (4-bit X/Y, Cin, 4-bit S, Co), one nibble per clock, LSB nibble first.
REQ-016 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-017 In IDLE, in_ready SHALL be 1; on in_valid&&in_ready, the block SHALL capture a into A_reg, b^{W{sub}} into B_reg, sub into carry_reg and sub into op_reg, clear nib_idx to 0 and go to RUN.
REQ-018 In RUN, each cycle the adder SHALL take X=A_reg nibble[nib_idx], Y=B_reg nibble[nib_idx] and Cin=carry_reg; S SHALL be written into sum nibble[nib_idx] and Co into carry_reg, and nib_idx SHALL increment.
REQ-019 When nib_idx==N_NIB-1 in RUN, the block SHALL write the last nibble, then go to DONE; nib_idx SHALL never exceed N_NIB-1 (no wrap).
REQ-020 Latency: out_valid SHALL rise exactly N_NIB cycles after the accepting edge (4 for the default).
REQ-021 In DONE, out_valid SHALL be 1 and sum/cout/ovf SHALL be stable until the handshake; on out_valid&&out_ready the block SHALL return to IDLE.
REQ-022 in_ready SHALL be 0 in RUN and DONE; the block SHALL NOT accept a request in the same cycle a result is taken (the next accept is earliest one cycle later).
REQ-023 ovf SHALL equal (A_reg[W-1]==B_reg[W-1]) && (sum[W-1]!=A_reg[W-1]), using the inverted B_reg for sub.
REQ-024 cout SHALL equal carry_reg after the final nibble.
REQ-025 in_valid SHALL be ignored outside IDLE, and input changes during RUN SHALL NOT affect the result.
REQ-026 out_ready asserted while not in DONE SHALL have no effect.

Reset
REQ-027 When rst=1 at a clock edge, the block SHALL go to IDLE with in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, nib_idx=0, carry_reg=0 and op_reg=0.
REQ-028 Reset SHALL take priority over all other events, including mid-RUN and in DONE with out_ready=1; any partial result SHALL be discarded.

Structure
REQ-029 A shared package SHALL hold the FSM state enum (IDLE, RUN, DONE; 2-bit encoding) and the constant NIB=4.
REQ-030 The adder SHALL be the codebase's existing 4-bit ripple adder, instantiated exactly once as the single sub-module.
REQ-031 No other arithmetic SHALL be inferred beyond the nib_idx counter and the ovf compare.

Verification
REQ-032 Scenario: a=0x1234, b=0x4321, sub=0 -> after 4 cycles sum=0x5555, cout=0, ovf=0.
REQ-033 Scenario: a=0xFFFF, b=0x0001, sub=0 -> sum=0x0000, cout=1, ovf=0; and a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1.
REQ-034 Scenario: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0, ovf=0; and a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1.
REQ-035 Scenario: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands -> out_valid, sum and cout stay stable and in_ready=0; after out_ready=1 -> IDLE, then the next request is accepted.
REQ-036 Scenario: assert rst for 1 cycle after the second RUN cycle -> next cycle state is IDLE, out_valid=0, sum=0; a fresh 0x0001+0x0001 then returns 0x0002.
REQ-037 Scenario: back-to-back requests with out_ready tied to 1 -> one result per N_NIB+2 cycles, all matching a reference model over 1000 random operands.
